// File: rtl/scancode_hex_display.sv
// Buffered hex-entry display fed by PS/2 set-1 scan codes.
// Digits shift in from the right and are scanned onto a 7-segment bank.
module scancode_hex_display #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         code_valid,
    input  logic [7:0]                   code,
    output logic [6:0]                   seg,
    output logic [DIGITS-1:0]            an,
    output logic [$clog2(DIGITS+1)-1:0]  count,
    output logic                         overflow
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [3:0]        digit_q [DIGITS];
    logic [RW-1:0]     refresh;
    logic [IW-1:0]     idx;
    logic              hex_hit;
    logic [3:0]        nib;
    logic [6:0]        lit_pat;
    logic [DIGITS-1:0] sel;

    function automatic logic [6:0] seg_pattern(input logic [3:0] n);
        case (n)
            4'h0: seg_pattern = 7'b1000000;
            4'h1: seg_pattern = 7'b1111001;
            4'h2: seg_pattern = 7'b0100100;
            4'h3: seg_pattern = 7'b0110000;
            4'h4: seg_pattern = 7'b0011001;
            4'h5: seg_pattern = 7'b0010010;
            4'h6: seg_pattern = 7'b0000010;
            4'h7: seg_pattern = 7'b1111000;
            4'h8: seg_pattern = 7'b0000000;
            4'h9: seg_pattern = 7'b0010000;
            4'hA: seg_pattern = 7'b0001000;
            4'hB: seg_pattern = 7'b0000011;
            4'hC: seg_pattern = 7'b1000110;
            4'hD: seg_pattern = 7'b0100001;
            4'hE: seg_pattern = 7'b0000110;
            default: seg_pattern = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        hex_hit = 1'b1;
        nib     = 4'h0;
        case (code)
            8'h0B: nib = 4'h0;
            8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
            8'h07, 8'h08, 8'h09, 8'h0A: nib = code[3:0] - 4'd1;
            8'h1E: nib = 4'hA;
            8'h30: nib = 4'hB;
            8'h2E: nib = 4'hC;
            8'h20: nib = 4'hD;
            8'h12: nib = 4'hE;
            8'h21: nib = 4'hF;
            default: hex_hit = 1'b0;
        endcase
    end

    // Entry buffer: digit 0 is the newest (rightmost) nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) digit_q[i] <= 4'h0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (code_valid) begin
            if (hex_hit) begin
                for (int i = DIGITS - 1; i > 0; i--) digit_q[i] <= digit_q[i-1];
                digit_q[0] <= nib;
                if (count == CW'(DIGITS)) overflow <= 1'b1;
                else count <= count + 1'b1;
            end else if (code == 8'h0E) begin
                if (count != '0) begin
                    for (int i = 0; i < DIGITS - 1; i++) digit_q[i] <= digit_q[i+1];
                    digit_q[DIGITS-1] <= 4'h0;
                    count <= count - 1'b1;
                end
            end else if (code == 8'h01) begin
                for (int i = 0; i < DIGITS; i++) digit_q[i] <= 4'h0;
                count    <= '0;
                overflow <= 1'b0;
            end
        end
    end

    assign lit_pat = (CW'(idx) < count) ? seg_pattern(digit_q[idx]) : 7'b1111111;
    assign sel     = DIGITS'(1) << idx;

    // seg/an are registered from the same idx so they always switch together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh <= '0;
            idx     <= '0;
            seg     <= ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
            an      <= ACTIVE_LOW ? ~DIGITS'(1) : DIGITS'(1);
        end else begin
            if (refresh == RW'(REFRESH_DIV - 1)) begin
                refresh <= '0;
                idx     <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                refresh <= refresh + 1'b1;
            end
            seg <= ACTIVE_LOW ? lit_pat : ~lit_pat;
            an  <= ACTIVE_LOW ? ~sel : sel;
        end
    end

endmodule

// File: tb/tb_scancode_hex_display.sv
// Randomized bench for scancode_hex_display with a queue-based reference.
// Two instances: slow active-low scan and every-cycle active-high scan.
module tb_scancode_hex_display;

    localparam int D  = 4;
    localparam int RA = 4;
    localparam int RB = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       code_valid = 1'b0;
    logic [7:0] code = 8'h00;

    logic [6:0]   seg_a, seg_b;
    logic [D-1:0] an_a, an_b;
    logic [2:0]   count_a, count_b;
    logic         ovf_a, ovf_b;

    int total = 0;
    int bad   = 0;

    int q[$];
    bit m_ovf = 1'b0;
    int edges = 0;

    scancode_hex_display #(.DIGITS(D), .REFRESH_DIV(RA), .ACTIVE_LOW(1)) dut_a (
        .clk(clk), .rst(rst), .code_valid(code_valid), .code(code),
        .seg(seg_a), .an(an_a), .count(count_a), .overflow(ovf_a)
    );

    scancode_hex_display #(.DIGITS(D), .REFRESH_DIV(RB), .ACTIVE_LOW(0)) dut_b (
        .clk(clk), .rst(rst), .code_valid(code_valid), .code(code),
        .seg(seg_b), .an(an_b), .count(count_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(string tag, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [6:0] low_pat(int v);
        case (v)
            0: return 7'b1000000;   1: return 7'b1111001;
            2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  15: return 7'b0001110;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int hex_of(logic [7:0] c);
        case (c)
            8'h0B: return 0;
            8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
            8'h07, 8'h08, 8'h09, 8'h0A: return int'(c) - 1;
            8'h1E: return 10;
            8'h30: return 11;
            8'h2E: return 12;
            8'h20: return 13;
            8'h12: return 14;
            8'h21: return 15;
            default: return -1;
        endcase
    endfunction

    // Expected outputs after an edge depend on the state before that edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            edges = 0;
        end else begin
            int ia, ib, v;
            logic [6:0] es_a, es_b;
            logic [D-1:0] ea_a, ea_b;
            ia = (edges / RA) % D;
            ib = (edges / RB) % D;
            es_a = (ia < q.size()) ? low_pat(q[ia]) : 7'b1111111;
            es_b = (ib < q.size()) ? ~low_pat(q[ib]) : 7'b0000000;
            ea_a = ~(D'(1) << ia);
            ea_b = D'(1) << ib;
            if (code_valid) begin
                v = hex_of(code);
                if (v >= 0) begin
                    q.push_front(v);
                    if (q.size() > D) begin
                        void'(q.pop_back());
                        m_ovf = 1'b1;
                    end
                end else if (code == 8'h0E) begin
                    if (q.size() > 0) void'(q.pop_front());
                end else if (code == 8'h01) begin
                    q.delete();
                    m_ovf = 1'b0;
                end
            end
            edges++;
            #1;
            expect_eq("seg_a", 32'(seg_a), 32'(es_a));
            expect_eq("an_a", 32'(an_a), 32'(ea_a));
            expect_eq("count_a", 32'(count_a), 32'(q.size()));
            expect_eq("ovf_a", 32'(ovf_a), 32'(m_ovf));
            expect_eq("seg_b", 32'(seg_b), 32'(es_b));
            expect_eq("an_b", 32'(an_b), 32'(ea_b));
            expect_eq("count_b", 32'(count_b), 32'(q.size()));
            expect_eq("ovf_b", 32'(ovf_b), 32'(m_ovf));
        end
    end

    task automatic send(logic [7:0] c);
        @(negedge clk);
        code_valid = 1'b1;
        code       = c;
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_check(string tag);
        expect_eq({tag, "_seg_a"}, 32'(seg_a), 32'h7F);
        expect_eq({tag, "_an_a"}, 32'(an_a), 32'b1110);
        expect_eq({tag, "_cnt"}, 32'(count_a), 32'd0);
        expect_eq({tag, "_ovf"}, 32'(ovf_a), 32'd0);
        expect_eq({tag, "_seg_b"}, 32'(seg_b), 32'h00);
        expect_eq({tag, "_an_b"}, 32'(an_b), 32'b0001);
    endtask

    initial begin
        logic [7:0] pool [12];
        pool = '{8'h0B, 8'h02, 8'h0A, 8'h1E, 8'h30, 8'h21,
                 8'h12, 8'h0E, 8'h0E, 8'h01, 8'h82, 8'h9E};
        #12;
        reset_check("rst0");
        @(negedge clk);
        rst = 1'b0;
        idle(3);

        send(8'h02); send(8'h1E); send(8'h0B);
        expect_eq("entry_cnt", 32'(count_a), 32'd3);
        idle(24);

        send(8'h01);
        for (int k = 0; k < 5; k++) send(8'h02 + 8'(k));
        expect_eq("ovf_cnt", 32'(count_a), 32'd4);
        expect_eq("ovf_flag", 32'(ovf_a), 32'd1);
        send(8'h82);
        expect_eq("break_cnt", 32'(count_a), 32'd4);
        idle(20);

        send(8'h0E); send(8'h0E);
        expect_eq("bs_cnt", 32'(count_a), 32'd2);
        expect_eq("bs_ovf", 32'(ovf_a), 32'd1);
        idle(20);
        send(8'h01);
        expect_eq("esc_cnt", 32'(count_a), 32'd0);
        expect_eq("esc_ovf", 32'(ovf_a), 32'd0);
        send(8'h0E);
        expect_eq("bs0_cnt", 32'(count_a), 32'd0);
        idle(4);

        @(negedge clk);
        code_valid = 1'b1; code = 8'h21;
        @(negedge clk); code = 8'h12;
        @(negedge clk); code = 8'h20;
        @(negedge clk); code_valid = 1'b0;
        expect_eq("b2b_cnt", 32'(count_a), 32'd3);
        idle(20);

        @(negedge clk);
        #2 rst = 1'b1;
        #1 reset_check("rst1");
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            code_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) code = 8'($urandom);
            else code = pool[$urandom_range(0, 11)];
        end
        @(negedge clk);
        code_valid = 1'b0;
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scancode_hex_display.md
# scancode_hex_display

Multi-digit hexadecimal entry display. It accepts PS/2 scan-code-set-1 bytes from the keyboard receiver and stores hex key presses in a DIGITS-deep shift buffer. It time-multiplexes the buffer onto a common-segment 7-segment display bank. It sits between the PS/2 byte receiver and the board's segment/anode pins, replacing the single-digit combinational decoder with a buffered, scanned, editable display.

## Interface
- DIGITS, 4: number of display digits and buffer depth (≥1).
- REFRESH_DIV, 50000: clock cycles each digit stays lit (≥1).
- ACTIVE_LOW, 1: 1 means segments and anodes are active-low; 0 means both are inverted to active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- code_valid  in  1  one-cycle strobe; code is valid this cycle.
- code  in  8  scan-code-set-1 byte.
- seg  out  7  {g,f,e,d,c,b,a}, registered.
- an  out  DIGITS  digit enables, one-hot, registered; an[0] is the rightmost digit.
- count  out  $clog2(DIGITS+1)  number of digits currently entered.
- overflow  out  1  sticky; set when an entry pushed out the oldest digit.

## Operation
- **Ignored codes:** codes with bit 7 set (break codes) are ignored, as is any code not listed below.
- **Hex keys:** make codes 0x0B,0x02..0x0A give digits 0..9; 0x1E=A, 0x30=B, 0x2E=C, 0x20=D, 0x12=E, 0x21=F.
  - Buffer shifts left by one digit; the new nibble goes into digit 0.
  - count increments, saturating at DIGITS.
  - If count==DIGITS before the shift, the digit DIGITS-1 value is discarded and overflow is set.
- **0x0E (Backspace):** buffer shifts right and digit DIGITS-1 becomes empty.
  - count decrements; if count==0 there is no change.
  - overflow is unchanged.
- **0x01 (Escape):** all digits become empty, count=0, overflow=0.
- **Empty digits:** positions ≥ count are empty and displayed blank (all segments off).
- **Segment patterns:** active-low form, {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - blank=1111111
  - With ACTIVE_LOW=0, seg and an are bitwise inverted.
- **Scan:** refresh counter 0..REFRESH_DIV-1. At terminal count it wraps to 0 and digit index advances 0→1→…→DIGITS-1→0.
- **Scanned outputs:** an selects the digit under the index; seg shows the pattern of that digit.

## Timing
- **Reset values (asynchronous, immediate):**
  - buffer all empty, count=0, overflow=0
  - refresh counter=0, index=0
  - seg=blank (1111111 when ACTIVE_LOW=1)
  - an=digit 0 enabled (~1 in low bits when ACTIVE_LOW=1)
- **Code latency:** a code with code_valid in cycle N updates buffer, count and overflow at the clock edge ending cycle N. These are visible on count/overflow in cycle N+1.
- **Display latency:** seg reflects a buffer change at the next registered scan update of that digit. Worst case is DIGITS·REFRESH_DIV+1 cycles.
- **Scan latency:** index changes on the edge where refresh counter wraps. seg and an are updated together on the following edge, so they are never mismatched for a cycle.
- **REFRESH_DIV=1:** index advances every cycle.
- **Back-to-back codes:** code_valid may be high every cycle and each code is processed; there is no backpressure.
- **Independence:** code handling and scanning are independent; a code arriving on a scan boundary affects neither the scan timing nor itself.
- **Reset mid-entry or mid-scan:** all state returns to reset values with no partial update.

## Test plan
- **Reset:** assert rst mid-scan → seg=1111111, an=1110, count=0, overflow=0 immediately.
- **Entry:** DIGITS=4, REFRESH_DIV=4; send 0x02,0x1E,0x0B → count=3.
  - Digit 0 shows 1000000 (0), digit 1 shows 0001000 (A), digit 2 shows 1111001 (1), digit 3 is blank.
  - Each digit is held 4 cycles with the an sequence 1110,1101,1011,0111.
- **Overflow:** send 5 hex keys 0x02..0x06 → count=4, overflow=1.
  - Display digits 3..0 show 2,3,4,5.
  - Break code 0x82 afterwards changes nothing.
- **Backspace:** after the above, send 0x0E twice → count=2, display shows 2,3 on digits 1..0, overflow still 1.
  - Send 0x01 → count=0, overflow=0, all blank.
  - 0x0E at count=0 → no change.
- **Back-to-back and polarity:** code_valid high 3 consecutive cycles with 0x21,0x12,0x20 → digits 2..0 show F,E,d.
  - With ACTIVE_LOW=0, digit 0 seg=1011110 and an=0001 when selected.
